// File: rtl/alert_cond_pkg.sv
// Shared types and widths for the alert-condition qualification stage.
// Holds the persistence filter state encoding and the sample widths.
package alert_pkg;

    localparam int BATT_W = 12;
    localparam int SPD_W  = 12;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        CLEAR     = 2'd0,
        ARMING    = 2'd1,
        SET       = 2'd2,
        DISARMING = 2'd3
    } filt_state_t;

    // The alert is visible once qualification has completed, including while it is being disarmed.
    function automatic logic flag_of(input filt_state_t st);
        return (st == SET) || (st == DISARMING);
    endfunction

endpackage

// File: rtl/alert_cond_if.sv
// Sample bus from the A2D/balance-control side into alert_cond, plus the
// three qualified alert flags returned towards the piezo driver.
interface alert_cond_if;
    import alert_pkg::*;

    logic              smpl_vld;
    logic [BATT_W-1:0] batt;
    logic [SPD_W-1:0]  lft_spd;
    logic [SPD_W-1:0]  rght_spd;
    logic              en_steer;
    logic              moving;
    logic              ovr_spd;
    logic              batt_low;

    modport master (
        output smpl_vld, batt, lft_spd, rght_spd, en_steer,
        input  moving, ovr_spd, batt_low
    );

    modport slave (
        input  smpl_vld, batt, lft_spd, rght_spd, en_steer,
        output moving, ovr_spd, batt_low
    );

endinterface

// File: rtl/alert_cond_persist_filt.sv
// Consecutive-sample persistence filter with a registered, glitch-free flag.
// force_clr overrides everything and does not wait for a sample strobe.
module persist_filt
    import alert_pkg::*;
#(
    parameter int PERSIST = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic smpl_vld,
    input  logic set_cond,
    input  logic clr_cond,
    input  logic force_clr,
    output logic flag
);

    localparam logic [CNT_W-1:0] P_C = CNT_W'(PERSIST);

    filt_state_t      r_state;
    filt_state_t      w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             r_flag;

    // Saturating increment so the count can never wrap past PERSIST.
    assign w_cnt_inc = (r_cnt >= P_C) ? P_C : (r_cnt + 4'd1);

    // Next-state logic; samples that fail the pending condition abandon a partial count.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (force_clr) begin
            w_state_nxt = CLEAR;
            w_cnt_nxt   = 4'd0;
        end else if (smpl_vld) begin
            case (r_state)
                CLEAR: begin
                    if (set_cond) begin
                        w_state_nxt = (P_C == 4'd1) ? SET : ARMING;
                        w_cnt_nxt   = (P_C == 4'd1) ? 4'd0 : 4'd1;
                    end else begin
                        w_state_nxt = CLEAR;
                        w_cnt_nxt   = 4'd0;
                    end
                end
                ARMING: begin
                    if (set_cond && (w_cnt_inc >= P_C)) begin
                        w_state_nxt = SET;
                        w_cnt_nxt   = 4'd0;
                    end else if (set_cond) begin
                        w_state_nxt = ARMING;
                        w_cnt_nxt   = w_cnt_inc;
                    end else begin
                        w_state_nxt = CLEAR;
                        w_cnt_nxt   = 4'd0;
                    end
                end
                SET: begin
                    if (clr_cond) begin
                        w_state_nxt = (P_C == 4'd1) ? CLEAR : DISARMING;
                        w_cnt_nxt   = (P_C == 4'd1) ? 4'd0 : 4'd1;
                    end else begin
                        w_state_nxt = SET;
                        w_cnt_nxt   = 4'd0;
                    end
                end
                DISARMING: begin
                    if (clr_cond && (w_cnt_inc >= P_C)) begin
                        w_state_nxt = CLEAR;
                        w_cnt_nxt   = 4'd0;
                    end else if (clr_cond) begin
                        w_state_nxt = DISARMING;
                        w_cnt_nxt   = w_cnt_inc;
                    end else begin
                        w_state_nxt = SET;
                        w_cnt_nxt   = 4'd0;
                    end
                end
                default: begin
                    w_state_nxt = CLEAR;
                    w_cnt_nxt   = 4'd0;
                end
            endcase
        end else begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
        end
    end

    // State, count and flag registers; the flag is taken from the next state to avoid an extra cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= CLEAR;
            r_cnt   <= 4'd0;
            r_flag  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_flag  <= flag_of(w_state_nxt);
        end
    end

    assign flag = r_flag;

endmodule

// File: rtl/alert_cond.sv
// Speed-magnitude arithmetic and threshold compares feeding three
// persistence filters that qualify the moving/over-speed/low-battery alerts.
module alert_cond
    import alert_pkg::*;
#(
    parameter logic [BATT_W-1:0] BATT_LOW_THRES = 12'h800,
    parameter logic [BATT_W-1:0] BATT_HYST      = 12'h040,
    parameter logic [SPD_W-1:0]  OVR_SPD_THRES  = 12'd1536,
    parameter logic [SPD_W-1:0]  SPD_HYST       = 12'd128,
    parameter logic [SPD_W-1:0]  MOVE_THRES     = 12'd64,
    parameter int                PERSIST        = 8
) (
    input  logic   clk,
    input  logic   rst_n,
    alert_cond_if.slave bus
);

    logic signed [SPD_W:0]   w_sum;
    logic signed [SPD_W:0]   w_avg;
    logic        [SPD_W-1:0] w_mag;
    logic                    w_batt_set;
    logic                    w_batt_clr;
    logic                    w_ovr_set;
    logic                    w_ovr_clr;
    logic                    w_move_set;
    logic                    w_moving;
    logic                    w_ovr_spd;
    logic                    w_batt_low;

    // 13-bit sum so -2048 + -2048 averages to -2048, whose magnitude 2048 still fits in 12 bits.
    assign w_sum = $signed({bus.lft_spd[SPD_W-1], bus.lft_spd})
                 + $signed({bus.rght_spd[SPD_W-1], bus.rght_spd});
    assign w_avg = w_sum >>> 1;
    assign w_mag = w_avg[SPD_W] ? (~w_avg[SPD_W-1:0] + 12'd1) : w_avg[SPD_W-1:0];

    assign w_batt_set = bus.batt < BATT_LOW_THRES;
    assign w_batt_clr = {1'b0, bus.batt} >= ({1'b0, BATT_LOW_THRES} + {1'b0, BATT_HYST});
    assign w_ovr_set  = w_mag > OVR_SPD_THRES;
    assign w_ovr_clr  = w_mag < (OVR_SPD_THRES - SPD_HYST);
    assign w_move_set = bus.en_steer && (w_mag >= MOVE_THRES);

    persist_filt #(.PERSIST(PERSIST)) u_batt_filt (
        .clk       (clk),
        .rst_n     (rst_n),
        .smpl_vld  (bus.smpl_vld),
        .set_cond  (w_batt_set),
        .clr_cond  (w_batt_clr),
        .force_clr (1'b0),
        .flag      (w_batt_low)
    );

    persist_filt #(.PERSIST(PERSIST)) u_ovr_filt (
        .clk       (clk),
        .rst_n     (rst_n),
        .smpl_vld  (bus.smpl_vld),
        .set_cond  (w_ovr_set),
        .clr_cond  (w_ovr_clr),
        .force_clr (1'b0),
        .flag      (w_ovr_spd)
    );

    // Leaving the platform drops the moving alert immediately, bypassing persistence.
    persist_filt #(.PERSIST(PERSIST)) u_move_filt (
        .clk       (clk),
        .rst_n     (rst_n),
        .smpl_vld  (bus.smpl_vld),
        .set_cond  (w_move_set),
        .clr_cond  (!w_move_set),
        .force_clr (!bus.en_steer),
        .flag      (w_moving)
    );

    assign bus.moving   = w_moving;
    assign bus.ovr_spd  = w_ovr_spd;
    assign bus.batt_low = w_batt_low;

endmodule

// File: tb/tb_alert_cond.sv
// Directed scoreboard bench for alert_cond: each stimulus cycle queues the
// hand-computed {moving, ovr_spd, batt_low} expected after the next clock edge.
module tb_alert_cond;

    typedef struct {
        logic [2:0] exp;
        string      nm;
    } sb_item_t;

    logic     clk;
    logic     rst_n;
    int       checks;
    int       failures;
    sb_item_t exp_q[$];

    alert_cond_if u_if ();

    alert_cond u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs and queue the flags expected after the following edge.
    task automatic step(input logic rstv, input logic vld, input logic [11:0] b,
                        input logic [11:0] l, input logic [11:0] r, input logic en,
                        input logic [2:0] exp, input string nm);
        sb_item_t it;
        @(posedge clk);
        #2;
        rst_n          = rstv;
        u_if.smpl_vld  = vld;
        u_if.batt      = b;
        u_if.lft_spd   = l;
        u_if.rght_spd  = r;
        u_if.en_steer  = en;
        it.exp = exp;
        it.nm  = nm;
        exp_q.push_back(it);
    endtask

    // Monitor: one edge after each queued cycle, compare outputs with the queued expectation.
    initial begin
        sb_item_t it;
        logic [2:0] got;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                it  = exp_q.pop_front();
                got = {u_if.moving, u_if.ovr_spd, u_if.batt_low};
                checks++;
                if (got !== it.exp) begin
                    failures++;
                    $display("FAIL %s: moving/ovr_spd/batt_low got %b required %b", it.nm, got, it.exp);
                end
            end
        end
    end

    initial begin
        checks   = 0;
        failures = 0;
        rst_n          = 1'b0;
        u_if.smpl_vld  = 1'b0;
        u_if.batt      = 12'h900;
        u_if.lft_spd   = 12'd0;
        u_if.rght_spd  = 12'd0;
        u_if.en_steer  = 1'b0;

        step(1'b0, 1'b0, 12'h900, 12'd0, 12'd0, 1'b0, 3'b000, "reset");
        step(1'b0, 1'b0, 12'h900, 12'd0, 12'd0, 1'b0, 3'b000, "reset");
        step(1'b1, 1'b0, 12'h900, 12'd0, 12'd0, 1'b0, 3'b000, "idle");

        // Battery low with hysteresis band.
        for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 12'h7F0, 12'd0, 12'd0, 1'b0, 3'b000, "batt_arm");
        step(1'b1, 1'b1, 12'h7F0, 12'd0, 12'd0, 1'b0, 3'b001, "batt_set");
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 12'h820, 12'd0, 12'd0, 1'b0, 3'b001, "batt_hyst");
        for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 12'h840, 12'd0, 12'd0, 1'b0, 3'b001, "batt_disarm");
        step(1'b1, 1'b1, 12'h840, 12'd0, 12'd0, 1'b0, 3'b000, "batt_clr");

        // Over-speed; a neutral sample restarts the count.
        for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 12'h900, 12'd1600, 12'd1600, 1'b0, 3'b000, "ovr_arm");
        step(1'b1, 1'b1, 12'h900, 12'd1500, 12'd1500, 1'b0, 3'b000, "ovr_neutral");
        for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 12'h900, 12'd1600, 12'd1600, 1'b0, 3'b000, "ovr_rearm");
        step(1'b1, 1'b1, 12'h900, 12'd1600, 12'd1600, 1'b0, 3'b010, "ovr_set");
        for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 12'h900, 12'd0, 12'd0, 1'b0, 3'b010, "ovr_disarm");
        step(1'b1, 1'b1, 12'h900, 12'd0, 12'd0, 1'b0, 3'b000, "ovr_clr");

        // Extreme negative speeds: magnitude 2048, then magnitude 1.
        for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 12'h900, 12'h800, 12'h800, 1'b0, 3'b000, "ovr_max_arm");
        step(1'b1, 1'b1, 12'h900, 12'h800, 12'h800, 1'b0, 3'b010, "ovr_max_set");
        for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 12'h900, 12'hFFF, 12'hFFF, 1'b0, 3'b010, "mag_one_disarm");
        step(1'b1, 1'b1, 12'h900, 12'hFFF, 12'hFFF, 1'b0, 3'b000, "mag_one_clr");

        // Moving, then forced clear by en_steer without a strobe.
        for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 12'h900, 12'd100, 12'd100, 1'b1, 3'b000, "move_arm");
        step(1'b1, 1'b1, 12'h900, 12'd100, 12'd100, 1'b1, 3'b100, "move_set");
        step(1'b1, 1'b0, 12'h900, 12'd100, 12'd100, 1'b0, 3'b000, "move_force");

        // All three together, then reset from SET and from mid-ARMING.
        for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 12'h7F0, 12'd1600, 12'd1600, 1'b1, 3'b000, "all_arm");
        step(1'b1, 1'b1, 12'h7F0, 12'd1600, 12'd1600, 1'b1, 3'b111, "all_set");
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 12'h7F0, 12'd1600, 12'd1600, 1'b1, 3'b111, "all_hold");
        step(1'b0, 1'b1, 12'h7F0, 12'd1600, 12'd1600, 1'b1, 3'b000, "rst_from_set");
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 12'h7F0, 12'd1600, 12'd1600, 1'b1, 3'b000, "rearm_partial");
        step(1'b0, 1'b1, 12'h7F0, 12'd1600, 12'd1600, 1'b1, 3'b000, "rst_mid_arm");
        for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 12'h7F0, 12'd1600, 12'd1600, 1'b1, 3'b000, "post_rst_arm");
        step(1'b1, 1'b1, 12'h7F0, 12'd1600, 12'd1600, 1'b1, 3'b111, "post_rst_set");
        step(1'b0, 1'b0, 12'h900, 12'd0, 12'd0, 1'b0, 3'b000, "rst_cleanup");

        // Violating inputs without strobes must not advance any filter.
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 12'h7F0, 12'h800, 12'h800, 1'b1, 3'b000, "no_vld");
        for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 12'h7F0, 12'h800, 12'h800, 1'b1, 3'b000, "no_vld_then_arm");
        step(1'b1, 1'b1, 12'h7F0, 12'h800, 12'h800, 1'b1, 3'b111, "no_vld_then_set");

        repeat (3) @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: queue holds %0d entries, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alert_cond.md
# alert_cond

Condition-qualification stage that produces the `moving`, `ovr_spd` and `batt_low` flags consumed by the piezo driver. It samples battery voltage and left/right wheel speed commands each time a new sample is strobed. It applies thresholds with hysteresis and consecutive-sample persistence, and drives three registered, glitch-free alert flags. It sits between the A2D/balance-control outputs and the piezo driver.

## Interface
- `BATT_LOW_THRES`, 12'h800, battery code below which the battery counts as low.
- `BATT_HYST`, 12'h040, added to `BATT_LOW_THRES` to form the release level.
- `OVR_SPD_THRES`, 12'd1536, speed magnitude above which the rider is over speed.
- `SPD_HYST`, 12'd128, subtracted from `OVR_SPD_THRES` to form the release level.
- `MOVE_THRES`, 12'd64, speed magnitude at or above which the rider is moving.
- `PERSIST`, 8, number of consecutive qualifying samples needed to change a flag (range 1–15).
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `smpl_vld`  in  1  one-cycle strobe; `batt`, `lft_spd` and `rght_spd` are valid on this cycle.
- `batt`  in  12  unsigned battery A2D code.
- `lft_spd`  in  12  signed left-wheel speed command.
- `rght_spd`  in  12  signed right-wheel speed command.
- `en_steer`  in  1  rider is on the platform and steering is enabled.
- `moving`  out  1  rider is moving; registered.
- `ovr_spd`  out  1  over-speed alert; registered.
- `batt_low`  out  1  low-battery alert; registered.

## Operation
- Inputs are evaluated only on cycles where `smpl_vld`=1. On other cycles all state holds.
- Speed magnitude:
  - sum = sign-extended 13-bit `lft_spd` + `rght_spd`.
  - avg = sum >>> 1, arithmetic.
  - mag = |avg|, 12-bit unsigned.
  - Worst case −2048 + −2048 gives mag = 2048, with no overflow.
- Each flag is driven by a persistence filter with states CLEAR, ARMING, SET, DISARMING and a 4-bit count.
  - CLEAR: when `set_cond` holds, count←1 and go to ARMING; if PERSIST=1, go directly to SET.
  - ARMING: `set_cond` increments count; when count reaches PERSIST, go to SET. A sample without `set_cond` returns the filter to CLEAR with count←0.
  - SET: `clr_cond` moves the filter to DISARMING with count←1, or directly to CLEAR if PERSIST=1.
  - DISARMING: `clr_cond` increments count; when count reaches PERSIST, go to CLEAR. A sample without `clr_cond` returns the filter to SET.
  - The flag output is 1 in SET and DISARMING, and 0 in CLEAR and ARMING.
- `batt_low` filter:
  - set_cond = `batt` < `BATT_LOW_THRES`.
  - clr_cond = `batt` ≥ `BATT_LOW_THRES` + `BATT_HYST`.
- `ovr_spd` filter:
  - set_cond = mag > `OVR_SPD_THRES`.
  - clr_cond = mag < `OVR_SPD_THRES` − `SPD_HYST`.
- `moving` filter:
  - set_cond = `en_steer` && mag ≥ `MOVE_THRES`.
  - clr_cond = !(set_cond).
  - If `en_steer` falls, `moving` is forced to CLEAR on the next clock, regardless of `smpl_vld` (this overrides persistence).
- The three filters are independent; simultaneous assertion of all three flags is legal. Priority between flags is resolved by the piezo driver, not here.
- Values between the set and release thresholds satisfy neither condition. Such a sample resets an in-progress ARMING or DISARMING count and otherwise holds the current state.

## Timing
- Reset: all filters go to CLEAR with count 0. `moving`, `ovr_spd` and `batt_low` reset to 0.
- Latency: a flag changes on the clock edge after the cycle carrying the PERSIST-th consecutive qualifying `smpl_vld`, i.e. one register stage after that sample.
- `en_steer` deassertion clears `moving` one clock later.
- Reset asserted mid-ARMING discards the partial count. After reset is released, the full PERSIST samples are required again.
- Back-to-back `smpl_vld` strobes on every clock are supported.
- The count saturates at PERSIST and never wraps.

## Structure
- Package `alert_pkg`:
  - `filt_state_t` enum {CLEAR, ARMING, SET, DISARMING}.
  - Width constants `BATT_W`=12 and `SPD_W`=12.
- Sub-module `persist_filt`: inputs clk, rst_n, smpl_vld, set_cond, clr_cond, force_clr; output flag. Parameter PERSIST. Instantiated three times.
- The top level holds only the magnitude arithmetic and the threshold compares.

## Test plan
- `batt`=12'h7F0 for 8 strobes → `batt_low` rises after strobe 8, not after strobe 7. `batt`=12'h820 → stays 1. `batt`=12'h840 for 8 strobes → falls.
- `lft_spd`=`rght_spd`=1600 for 7 strobes, then 1500 once, then 1600 for 8 strobes → `ovr_spd` rises only after the final 8th strobe.
- `lft_spd`=`rght_spd`=−2048 → mag 2048, `ovr_spd` sets after 8 strobes, no overflow. −1 and −1 → mag 1.
- `en_steer`=1 and speed 100 for 8 strobes → `moving`=1. Drop `en_steer` with no `smpl_vld` → `moving`=0 next clock.
- All three set conditions held simultaneously → all three flags rise on the same edge. Assert `rst_n`=0 mid-ARMING → all outputs 0, and a full 8 strobes are needed again after release.
- `smpl_vld` held 0 while inputs violate thresholds → no flag or state change.
